// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell encoding, direction step tables and
// the move_controller state enum (also shown on the main controller debug display).
package othello_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    // Indexed by direction 0..7 = N, NE, E, SE, S, SW, W, NW; 4-bit two's complement steps
    localparam logic [7:0][3:0] DIR_DX = {4'hF, 4'hF, 4'hF, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
    localparam logic [7:0][3:0] DIR_DY = {4'hF, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'hF, 4'hF};

    typedef enum logic [3:0] {
        MV_IDLE,
        MV_RD_TGT,
        MV_EV_TGT,
        MV_DIR_INIT,
        MV_SCAN_RD,
        MV_SCAN_EV,
        MV_FLIP,
        MV_NEXT_DIR,
        MV_PLACE,
        MV_DONE,
        MV_REJECT
    } mv_state_t;

    function automatic logic [1:0] own_cell(input logic player);
        return player ? CELL_WHITE : CELL_BLACK;
    endfunction

    function automatic logic [1:0] opp_cell(input logic player);
        return player ? CELL_BLACK : CELL_WHITE;
    endfunction

endpackage

// File: rtl/move_step.sv
// One board step from (x, y) in direction dir; in_bounds is low when the
// step would leave the 8x8 board, so callers never form a wrapped address.
module move_step
    import othello_pkg::*;
(
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic [2:0] dir,
    output logic [2:0] nx,
    output logic [2:0] ny,
    output logic       in_bounds
);

    logic [3:0] sx;
    logic [3:0] sy;

    // -1 and 8 both set bit 3, which is the only way a step can leave the board
    assign sx        = {1'b0, x} + DIR_DX[dir];
    assign sy        = {1'b0, y} + DIR_DY[dir];
    assign nx        = sx[2:0];
    assign ny        = sy[2:0];
    assign in_bounds = ~sx[3] & ~sy[3];

endmodule

// File: rtl/move_controller.sv
// Sequences one Othello move against the board RAM: target check, eight-way
// bracket scan, flips, placement, then ack or invalid to the main controller.
//   state    | meaning
//   IDLE     | waiting for new_move, latch player/cursor
//   RD_TGT   | read target cell
//   EV_TGT   | target occupied -> reject, else start at direction 0
//   DIR_INIT | first step of current direction
//   SCAN_RD  | read ray cell
//   SCAN_EV  | extend run, bracket found, or give up on direction
//   FLIP     | write own colour along the bracketed run
//   NEXT_DIR | advance direction or finish
//   PLACE    | write own colour at target
//   DONE     | ack held until new_move low
//   REJECT   | invalid held until new_move low
module move_controller
    import othello_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       new_move,
    input  logic       player,
    input  logic [2:0] cur_x,
    input  logic [2:0] cur_y,
    output logic [5:0] mem_addr,
    input  logic [1:0] mem_rdata,
    output logic [1:0] mem_wdata,
    output logic       mem_we,
    output logic       busy,
    output logic       ack,
    output logic       invalid,
    output logic [4:0] flip_count
);

    mv_state_t  state, state_n;
    logic       player_q, player_n;
    logic [2:0] tgt_x, tgt_x_n, tgt_y, tgt_y_n;
    logic [2:0] pos_x, pos_x_n, pos_y, pos_y_n;
    logic [2:0] dir, dir_n;
    logic [2:0] run, run_n;
    logic [4:0] flips_n;

    logic [2:0] tstep_x, tstep_y, pstep_x, pstep_y;
    logic       tstep_ok, pstep_ok;

    move_step u_step_tgt (
        .x(tgt_x), .y(tgt_y), .dir(dir),
        .nx(tstep_x), .ny(tstep_y), .in_bounds(tstep_ok)
    );

    move_step u_step_pos (
        .x(pos_x), .y(pos_y), .dir(dir),
        .nx(pstep_x), .ny(pstep_y), .in_bounds(pstep_ok)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= MV_IDLE;
            player_q   <= 1'b0;
            tgt_x      <= 3'd0;
            tgt_y      <= 3'd0;
            pos_x      <= 3'd0;
            pos_y      <= 3'd0;
            dir        <= 3'd0;
            run        <= 3'd0;
            flip_count <= 5'd0;
        end else begin
            state      <= state_n;
            player_q   <= player_n;
            tgt_x      <= tgt_x_n;
            tgt_y      <= tgt_y_n;
            pos_x      <= pos_x_n;
            pos_y      <= pos_y_n;
            dir        <= dir_n;
            run        <= run_n;
            flip_count <= flips_n;
        end
    end

    always_comb begin
        state_n  = state;
        player_n = player_q;
        tgt_x_n  = tgt_x;
        tgt_y_n  = tgt_y;
        pos_x_n  = pos_x;
        pos_y_n  = pos_y;
        dir_n    = dir;
        run_n    = run;
        flips_n  = flip_count;
        case (state)
            MV_IDLE: begin
                if (new_move) begin
                    player_n = player;
                    tgt_x_n  = cur_x;
                    tgt_y_n  = cur_y;
                    flips_n  = 5'd0;
                    state_n  = MV_RD_TGT;
                end
            end
            MV_RD_TGT: state_n = MV_EV_TGT;
            MV_EV_TGT: begin
                if (mem_rdata == CELL_BLACK || mem_rdata == CELL_WHITE) begin
                    state_n = MV_REJECT;
                end else begin
                    dir_n   = 3'd0;
                    state_n = MV_DIR_INIT;
                end
            end
            MV_DIR_INIT: begin
                pos_x_n = tstep_x;
                pos_y_n = tstep_y;
                run_n   = 3'd0;
                state_n = tstep_ok ? MV_SCAN_RD : MV_NEXT_DIR;
            end
            MV_SCAN_RD: state_n = MV_SCAN_EV;
            MV_SCAN_EV: begin
                if (mem_rdata == opp_cell(player_q)) begin
                    run_n = run + 3'd1;
                    if (pstep_ok) begin
                        pos_x_n = pstep_x;
                        pos_y_n = pstep_y;
                        state_n = MV_SCAN_RD;
                    end else begin
                        state_n = MV_NEXT_DIR;
                    end
                end else if (mem_rdata == own_cell(player_q) && run != 3'd0) begin
                    // Rewind to the first disc next to the target and flip outward
                    pos_x_n = tstep_x;
                    pos_y_n = tstep_y;
                    state_n = MV_FLIP;
                end else begin
                    state_n = MV_NEXT_DIR;
                end
            end
            MV_FLIP: begin
                pos_x_n = pstep_x;
                pos_y_n = pstep_y;
                run_n   = run - 3'd1;
                flips_n = flip_count + 5'd1;
                if (run == 3'd1) state_n = MV_NEXT_DIR;
            end
            MV_NEXT_DIR: begin
                if (dir == 3'd7) begin
                    state_n = (flip_count != 5'd0) ? MV_PLACE : MV_REJECT;
                end else begin
                    dir_n   = dir + 3'd1;
                    state_n = MV_DIR_INIT;
                end
            end
            MV_PLACE: state_n = MV_DONE;
            MV_DONE: begin
                if (!new_move) state_n = MV_IDLE;
            end
            MV_REJECT: begin
                flips_n = 5'd0;
                if (!new_move) state_n = MV_IDLE;
            end
            default: state_n = MV_IDLE;
        endcase
    end

    always_comb begin
        case (state)
            MV_RD_TGT, MV_PLACE: mem_addr = {tgt_y, tgt_x};
            MV_SCAN_RD, MV_FLIP: mem_addr = {pos_y, pos_x};
            default:             mem_addr = 6'd0;
        endcase
    end

    assign mem_we    = (state == MV_FLIP) || (state == MV_PLACE);
    assign mem_wdata = (state == MV_IDLE) ? CELL_EMPTY : own_cell(player_q);
    assign busy      = !(state == MV_IDLE || state == MV_DONE || state == MV_REJECT);
    assign ack       = (state == MV_DONE);
    assign invalid   = (state == MV_REJECT);

endmodule

// File: tb/tb_move_controller.sv
// Table-driven bench for move_controller with a board RAM model and a
// write scoreboard filled from an independent Othello reference model.
module tb_move_controller;

    logic       clock;
    logic       reset;
    logic       new_move;
    logic       player;
    logic [2:0] cur_x;
    logic [2:0] cur_y;
    logic [5:0] mem_addr;
    logic [1:0] mem_rdata;
    logic [1:0] mem_wdata;
    logic       mem_we;
    logic       busy;
    logic       ack;
    logic       invalid;
    logic [4:0] flip_count;

    move_controller dut (
        .clock(clock), .reset(reset), .new_move(new_move), .player(player),
        .cur_x(cur_x), .cur_y(cur_y), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy), .ack(ack),
        .invalid(invalid), .flip_count(flip_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [1:0] board     [64];
    logic [1:0] ref_board [64];
    logic       ld_en;

    always @(posedge clock) begin
        mem_rdata <= board[mem_addr];
        if (ld_en) board <= ref_board;
        else if (mem_we) board[mem_addr] <= mem_wdata;
    end

    typedef struct {
        int setup;
        bit pl;
        int x;
        int y;
        bit exp_ack;
        bit exp_inv;
        int exp_flips;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] wr_q[$];
    int checks;
    int passed;
    int dxt[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dyt[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic put(input int x, input int y, input logic [1:0] v);
        ref_board[y*8+x] = v;
    endtask

    task automatic load_board(input int setup);
        for (int i = 0; i < 64; i++) ref_board[i] = 2'b00;
        case (setup)
            0: begin
                put(3, 3, 2'b10); put(4, 4, 2'b10); put(4, 3, 2'b01); put(3, 4, 2'b01);
            end
            1: begin
                put(6, 6, 2'b01); put(5, 5, 2'b01); put(4, 4, 2'b10);
            end
            2: begin
                put(5, 4, 2'b10); put(5, 3, 2'b10); put(5, 2, 2'b10); put(5, 1, 2'b01);
                put(4, 5, 2'b10); put(3, 5, 2'b10); put(2, 5, 2'b01);
            end
            default: begin
                put(1, 0, 2'b01); put(2, 0, 2'b11);
                for (int i = 1; i < 8; i++) put(i, 7, 2'b10);
            end
        endcase
        ld_en = 1'b1;
        @(posedge clock);
        #1;
        ld_en = 1'b0;
    endtask

    function automatic bit off_board(input int x, input int y);
        return (x < 0) || (x > 7) || (y < 0) || (y > 7);
    endfunction

    // Reference: pushes expected writes and returns flips and result latency in cycles
    task automatic model_move(input bit pl, input int x, input int y,
                              output int flips, output int cycles);
        logic [1:0] own_c, opp_c, c;
        int cx, cy, run, scanned;
        bit found, stop;
        own_c  = pl ? 2'b10 : 2'b01;
        opp_c  = pl ? 2'b01 : 2'b10;
        flips  = 0;
        cycles = 3;
        if (ref_board[y*8+x] == 2'b01 || ref_board[y*8+x] == 2'b10) return;
        for (int d = 0; d < 8; d++) begin
            cx = x + dxt[d];
            cy = y + dyt[d];
            if (off_board(cx, cy)) begin
                cycles += 2;
                continue;
            end
            run = 0; scanned = 0; found = 0; stop = 0;
            while (!stop) begin
                scanned++;
                c = ref_board[cy*8+cx];
                if (c == opp_c) begin
                    run++;
                    cx += dxt[d];
                    cy += dyt[d];
                    if (off_board(cx, cy)) stop = 1;
                end else begin
                    found = (c == own_c) && (run > 0);
                    stop  = 1;
                end
            end
            cycles += 2 + 2 * scanned;
            if (found) begin
                cycles += run;
                flips  += run;
                for (int k = 1; k <= run; k++)
                    wr_q.push_back({6'((y + k*dyt[d])*8 + x + k*dxt[d]), own_c});
            end
        end
        if (flips > 0) begin
            cycles += 1;
            wr_q.push_back({6'(y*8+x), own_c});
        end
    endtask

    task automatic sample_wr(input string tag);
        logic [7:0] e;
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                check({tag, " unexpected write"}, int'({mem_addr, mem_wdata}), -1);
            end else begin
                e = wr_q.pop_front();
                check({tag, " write addr/data"}, int'({mem_addr, mem_wdata}), int'(e));
            end
        end
    endtask

    task automatic run_move(input int idx, input bit drop_early);
        int flips_m, cyc_m, k;
        bit got;
        string tag;
        tag = $sformatf("v%0d", idx);
        load_board(vecs[idx].setup);
        model_move(vecs[idx].pl, vecs[idx].x, vecs[idx].y, flips_m, cyc_m);
        @(negedge clock);
        new_move = 1'b1;
        player   = vecs[idx].pl;
        cur_x    = 3'(vecs[idx].x);
        cur_y    = 3'(vecs[idx].y);
        k = 0;
        got = 0;
        while (!got && k < 400) begin
            @(negedge clock);
            k++;
            if (drop_early && k == 2) new_move = 1'b0;
            sample_wr(tag);
            if (ack || invalid) got = 1;
        end
        if (!got) check({tag, " result timeout"}, 0, 1);
        check({tag, " result cycle"}, k, cyc_m);
        check({tag, " ack"}, int'(ack), int'(vecs[idx].exp_ack));
        check({tag, " invalid"}, int'(invalid), int'(vecs[idx].exp_inv));
        check({tag, " flip_count"}, int'(flip_count), vecs[idx].exp_flips);
        check({tag, " busy at result"}, int'(busy), 0);
        if (!drop_early) begin
            @(negedge clock);
            check({tag, " result held"}, int'(ack | invalid), 1);
            new_move = 1'b0;
        end
        @(negedge clock);
        check({tag, " result released"}, int'(ack | invalid), 0);
        check({tag, " pending writes"}, wr_q.size(), 0);
        wr_q.delete();
    endtask

    initial begin
        int flips_m, cyc_m, wr_seen, k;
        checks   = 0;
        passed   = 0;
        ld_en    = 1'b0;
        reset    = 1'b1;
        new_move = 1'b0;
        player   = 1'b0;
        cur_x    = 3'd0;
        cur_y    = 3'd0;

        vecs[0] = '{0, 1'b0, 2, 3, 1'b1, 1'b0, 1};
        vecs[1] = '{0, 1'b0, 3, 3, 1'b0, 1'b1, 0};
        vecs[2] = '{0, 1'b0, 0, 0, 1'b0, 1'b1, 0};
        vecs[3] = '{1, 1'b1, 7, 7, 1'b1, 1'b0, 2};
        vecs[4] = '{2, 1'b0, 5, 5, 1'b1, 1'b0, 5};
        vecs[5] = '{3, 1'b1, 0, 0, 1'b0, 1'b1, 0};
        vecs[6] = '{3, 1'b0, 0, 7, 1'b0, 1'b1, 0};
        vecs[7] = '{0, 1'b1, 4, 2, 1'b1, 1'b0, 1};

        repeat (2) @(negedge clock);
        check("reset outputs", int'({mem_addr, mem_wdata, mem_we, busy, ack, invalid, flip_count}), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_move(i, 1'b0);

        // new_move dropped mid-move: result still appears for exactly one cycle
        run_move(0, 1'b1);

        // reset during the second FLIP cycle of the multi-direction move
        load_board(2);
        model_move(1'b0, 5, 5, flips_m, cyc_m);
        @(negedge clock);
        new_move = 1'b1;
        player   = 1'b0;
        cur_x    = 3'd5;
        cur_y    = 3'd5;
        wr_seen  = 0;
        k        = 0;
        while (wr_seen < 2 && k < 400) begin
            @(negedge clock);
            k++;
            if (mem_we) wr_seen++;
            sample_wr("rst");
        end
        check("rst reached second flip", wr_seen, 2);
        #1;
        reset    = 1'b1;
        new_move = 1'b0;
        @(posedge clock);
        #1;
        check("rst outputs cleared",
              int'({mem_addr, mem_wdata, mem_we, busy, ack, invalid, flip_count}), 0);
        @(negedge clock);
        reset = 1'b0;
        wr_q.delete();
        run_move(0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
